skin_frame_ctrl: RTL and testbench

SKIN_FRAME_CTRL -- requirements
Module: skin_frame_ctrl

---
 rtl/skin_pkg.sv | 10 +
 rtl/skin_xy_counter.sv | 30 +++
 rtl/skin_frame_ctrl.sv | 104 ++++++++++
 tb/tb_skin_frame_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/skin_pkg.sv
// skin_pkg: shared FSM state type, default frame geometry and datapath widths
package skin_pkg;
   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, REPORT} state_t;
   localparam int DEF_FRAME_W  = 640;
   localparam int DEF_FRAME_H  = 480;
   localparam int DEF_MIN_SKIN = 1024;
   localparam int CNT_W        = 19;
   localparam int X_W          = 10;
   localparam int Y_W          = 9;
endpackage

// File: rtl/skin_xy_counter.sv
// skin_xy_counter: raster x/y position of the next pixel with end-of-frame flag
// Ports: clk, rst_n (async active-low), clr (restart at 0,0), step (one pixel
// transferred), x/y (position of the pixel being offered), last (x,y is the final pixel)
module skin_xy_counter import skin_pkg::*; #(
   parameter int FRAME_W = DEF_FRAME_W,
   parameter int FRAME_H = DEF_FRAME_H
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   input  logic           step,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           last
);
   logic x_end;
   assign x_end = x == X_W'(FRAME_W - 1);
   assign last  = x_end && y == Y_W'(FRAME_H - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else if (clr) begin
         x <= '0;
         y <= '0;
      end else if (step) begin
         x <= x_end ? '0 : x + 1'b1;
         y <= last ? '0 : x_end ? y + 1'b1 : y;
      end
endmodule

// File: rtl/skin_frame_ctrl.sv
// skin_frame_ctrl: per-frame skin-pixel counter, face detector and bounding-box tracker
// Ports: CLOCK_50, RST_N (async active-low); start; pix_valid/pix_ready pixel
// handshake; skin_bit (classifier result, one cycle after the transfer);
// res_valid/res_ready result handshake; skin_count, face_found, x_min/x_max/y_min/y_max.
// Macro SKIN_BBOX_EN builds the bounding-box tracker; without it the box outputs are 0.
module skin_frame_ctrl import skin_pkg::*; #(
   parameter int FRAME_W  = DEF_FRAME_W,
   parameter int FRAME_H  = DEF_FRAME_H,
   parameter int MIN_SKIN = DEF_MIN_SKIN
) (
   input  logic             CLOCK_50,
   input  logic             RST_N,
   input  logic             start,
   input  logic             pix_valid,
   output logic             pix_ready,
   input  logic             skin_bit,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] skin_count,
   output logic             face_found,
   output logic [X_W-1:0]   x_min,
   output logic [X_W-1:0]   x_max,
   output logic [Y_W-1:0]   y_min,
   output logic [Y_W-1:0]   y_max
);
   state_t           state;
   logic             xfer, clr, hit, d_valid, last;
   logic [X_W-1:0]   x;
   logic [Y_W-1:0]   y;
   logic [CNT_W-1:0] cnt_nxt;
   assign xfer    = pix_valid && pix_ready;
   assign clr     = state == IDLE && start;
   // skin_bit belongs to the pixel transferred on the previous cycle
   assign hit     = d_valid && skin_bit;
   assign cnt_nxt = skin_count + CNT_W'(hit && !(&skin_count));
   skin_xy_counter #(.FRAME_W(FRAME_W), .FRAME_H(FRAME_H)) u_xy (
      .clk(CLOCK_50), .rst_n(RST_N), .clr(clr), .step(xfer), .x(x), .y(y), .last(last)
   );
   always_ff @(posedge CLOCK_50 or negedge RST_N)
      if (!RST_N) begin
         state      <= IDLE;
         pix_ready  <= 1'b0;
         busy       <= 1'b0;
         res_valid  <= 1'b0;
         face_found <= 1'b0;
         skin_count <= '0;
         d_valid    <= 1'b0;
      end else begin
         d_valid    <= xfer;
         skin_count <= clr ? '0 : cnt_nxt;
         case (state)
            IDLE: if (start) begin
               state      <= ACTIVE;
               pix_ready  <= 1'b1;
               busy       <= 1'b1;
               face_found <= 1'b0;
            end
            ACTIVE: if (xfer && last) begin
               state     <= DRAIN;
               pix_ready <= 1'b0;
            end
            // the final pixel's skin_bit is counted on this edge, so compare the next count
            DRAIN: begin
               state      <= REPORT;
               res_valid  <= 1'b1;
               face_found <= cnt_nxt >= CNT_W'(MIN_SKIN);
            end
            REPORT: if (res_ready) begin
               state     <= IDLE;
               res_valid <= 1'b0;
               busy      <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
`ifdef SKIN_BBOX_EN
   logic [X_W-1:0] d_x;
   logic [Y_W-1:0] d_y;
   always_ff @(posedge CLOCK_50 or negedge RST_N)
      if (!RST_N) begin
         d_x   <= '0;
         d_y   <= '0;
         x_min <= X_W'(FRAME_W - 1);
         x_max <= '0;
         y_min <= Y_W'(FRAME_H - 1);
         y_max <= '0;
      end else begin
         d_x   <= x;
         d_y   <= y;
         x_min <= clr ? X_W'(FRAME_W - 1) : hit && d_x < x_min ? d_x : x_min;
         x_max <= clr ? '0 : hit && d_x > x_max ? d_x : x_max;
         y_min <= clr ? Y_W'(FRAME_H - 1) : hit && d_y < y_min ? d_y : y_min;
         y_max <= clr ? '0 : hit && d_y > y_max ? d_y : y_max;
      end
`else
   logic unused_xy;
   assign unused_xy = ^{x, y};
   assign x_min = '0;
   assign x_max = '0;
   assign y_min = '0;
   assign y_max = '0;
`endif
endmodule

// File: tb/tb_skin_frame_ctrl.sv
// tb_skin_frame_ctrl: directed frame vectors and corner sequences for skin_frame_ctrl
module tb_skin_frame_ctrl;
   import skin_pkg::*;
   localparam int W  = 8;
   localparam int H  = 4;
   localparam int MS = 3;
   logic CLOCK_50 = 1'b0, RST_N = 1'b0, start = 1'b0, pix_valid = 1'b0, skin_bit = 1'b0, res_ready = 1'b0;
   logic pix_ready, busy, res_valid, face_found;
   logic [CNT_W-1:0] skin_count;
   logic [X_W-1:0] x_min, x_max;
   logic [Y_W-1:0] y_min, y_max;
   int compared = 0, mismatched = 0;
   typedef struct {
      logic [31:0] mask;
      int cnt, face, xmin, xmax, ymin, ymax;
   } vec_t;
   vec_t vecs[6];
   skin_frame_ctrl #(.FRAME_W(W), .FRAME_H(H), .MIN_SKIN(MS)) dut (
      .CLOCK_50(CLOCK_50), .RST_N(RST_N), .start(start), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .skin_bit(skin_bit), .busy(busy), .res_valid(res_valid),
      .res_ready(res_ready), .skin_count(skin_count), .face_found(face_found),
      .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max)
   );
   always #5 CLOCK_50 = ~CLOCK_50;
   task automatic check(input string nm, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   task automatic check_box(input string nm, input int xn, input int xx, input int yn, input int yx);
`ifdef SKIN_BBOX_EN
      check({nm, " x_min"}, int'(x_min), xn);
      check({nm, " x_max"}, int'(x_max), xx);
      check({nm, " y_min"}, int'(y_min), yn);
      check({nm, " y_max"}, int'(y_max), yx);
`else
      check({nm, " x_min"}, int'(x_min), 0);
      check({nm, " x_max"}, int'(x_max), 0);
      check({nm, " y_min"}, int'(y_min), 0);
      check({nm, " y_max"}, int'(y_max), 0);
`endif
   endtask
   task automatic check_result(input string nm, input vec_t v);
      check({nm, " count"}, int'(skin_count), v.cnt);
      check({nm, " face"}, int'(face_found), v.face);
      check_box(nm, v.xmin, v.xmax, v.ymin, v.ymax);
   endtask
   task automatic check_reset(input string nm);
      check({nm, " pix_ready"}, int'(pix_ready), 0);
      check({nm, " busy"}, int'(busy), 0);
      check({nm, " res_valid"}, int'(res_valid), 0);
      check({nm, " face"}, int'(face_found), 0);
      check({nm, " count"}, int'(skin_count), 0);
      check_box(nm, W - 1, 0, H - 1, 0);
   endtask
   // rnd: random pix_valid; start_mid: pulse start mid-frame; hold: cycles res_ready stays 0;
   // start_acc: raise start together with res_ready
   task automatic run_frame(input vec_t v, input bit rnd, input bit start_mid, input int hold,
                            input bit start_acc, input string nm);
      bit x;
      int n = 0, cyc = 0;
      @(negedge CLOCK_50) start = 1'b1;
      @(negedge CLOCK_50) start = 1'b0;
      check({nm, " ready"}, int'(pix_ready), 1);
      check({nm, " busy"}, int'(busy), 1);
      while (n < W * H && cyc < 1000) begin
         pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         start = start_mid && n == 5;
         x = pix_valid && pix_ready;
         @(negedge CLOCK_50);
         cyc++;
         skin_bit = x ? v.mask[n] : 1'b0;
         if (x) n++;
      end
      start = 1'b0;
      check({nm, " transfers"}, n, W * H);
      pix_valid = 1'b1;
      check({nm, " drain res_valid"}, int'(res_valid), 0);
      check({nm, " drain ready"}, int'(pix_ready), 0);
      @(negedge CLOCK_50) skin_bit = 1'b0;
      check({nm, " res_valid"}, int'(res_valid), 1);
      check({nm, " report ready"}, int'(pix_ready), 0);
      check({nm, " report busy"}, int'(busy), 1);
      check_result(nm, v);
      repeat (hold) begin
         @(negedge CLOCK_50);
         check({nm, " hold res_valid"}, int'(res_valid), 1);
         check({nm, " hold ready"}, int'(pix_ready), 0);
         check_result({nm, " hold"}, v);
      end
      res_ready = 1'b1;
      start = start_acc;
      @(negedge CLOCK_50);
      res_ready = 1'b0;
      start = 1'b0;
      pix_valid = 1'b0;
      check({nm, " done res_valid"}, int'(res_valid), 0);
      check({nm, " done busy"}, int'(busy), 0);
      if (start_acc) begin
         @(negedge CLOCK_50);
         check({nm, " no restart busy"}, int'(busy), 0);
         check({nm, " no restart ready"}, int'(pix_ready), 0);
      end
   endtask
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      vecs[0] = '{32'h0008_2400, 3, 1, 2, 5, 1, 2};
      vecs[1] = '{32'h0000_0000, 0, 0, 7, 0, 3, 0};
      vecs[2] = '{32'h0000_0001, 1, 0, 0, 0, 0, 0};
      vecs[3] = '{32'hFFFF_FFFF, 32, 1, 0, 7, 0, 3};
      vecs[4] = '{32'h8000_0000, 1, 0, 7, 7, 3, 3};
      vecs[5] = '{32'h0100_0080, 2, 0, 0, 7, 0, 3};
      #12;
      check_reset("reset");
      @(negedge CLOCK_50) RST_N = 1'b1;
      @(negedge CLOCK_50);
      check_reset("idle");
      for (int i = 0; i < 6; i++) run_frame(vecs[i], 1'b0, 1'b0, 0, 1'b0, $sformatf("vec%0d", i));
      run_frame(vecs[0], 1'b1, 1'b0, 5, 1'b0, "rand_hold");
      run_frame(vecs[2], 1'b0, 1'b1, 0, 1'b1, "start_ignored");
      run_frame(vecs[1], 1'b0, 1'b0, 0, 1'b0, "clean_after_start");
      @(negedge CLOCK_50) start = 1'b1;
      @(negedge CLOCK_50) start = 1'b0;
      pix_valid = 1'b1;
      repeat (10) @(negedge CLOCK_50) skin_bit = 1'b1;
      pix_valid = 1'b0;
      RST_N = 1'b0;
      #1;
      check_reset("midframe_reset");
      skin_bit = 1'b0;
      @(negedge CLOCK_50) RST_N = 1'b1;
      repeat (3) begin
         @(negedge CLOCK_50);
         check("post_reset res_valid", int'(res_valid), 0);
         check("post_reset busy", int'(busy), 0);
      end
      run_frame(vecs[0], 1'b0, 1'b0, 0, 1'b0, "after_reset");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
